// File: rtl/multi_flex_counter.sv
// Multi-channel programmable-step counter with per-channel wrap (up/down) or bounce mode.
// Each channel emits a registered one-cycle pulse whenever it wraps or turns around.
module multi_flex_counter #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int STEP_W = 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         clear,
    input  logic [NUM_CH-1:0]         mode,
    input  logic [NUM_CH-1:0]         dir,
    input  logic [NUM_CH*STEP_W-1:0]  step,
    input  logic [NUM_CH*WIDTH-1:0]   rollover_val,
    output logic [NUM_CH*WIDTH-1:0]   count,
    output logic [NUM_CH-1:0]         rollover_flag,
    output logic [NUM_CH-1:0]         dir_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] count_q, count_d;
        logic             dir_q, dir_d;
        logic             flag_q, flag_d;
        logic [WIDTH:0]   r_ext, c_ext, s_ext, sum_ext, diff_ext;

        // One extra bit so count+step can never overflow the compare.
        assign r_ext    = {1'b0, rollover_val[i*WIDTH +: WIDTH]};
        assign c_ext    = {1'b0, count_q};
        assign s_ext    = (WIDTH+1)'(step[i*STEP_W +: STEP_W]);
        assign sum_ext  = c_ext + s_ext;
        assign diff_ext = c_ext - s_ext;

        always_comb begin
            count_d = count_q;
            dir_d   = dir_q;
            flag_d  = 1'b0;
            if (clear[i]) begin
                count_d = '0;
                dir_d   = 1'b1;
            end else if (!en[i] || (s_ext == '0)) begin
                count_d = count_q;
            end else if (c_ext > r_ext) begin
                // Rollover value lowered below the current count.
                count_d = '0;
                dir_d   = 1'b1;
                flag_d  = 1'b1;
            end else if (!mode[i]) begin
                if (dir[i]) begin
                    if (sum_ext > r_ext) begin
                        count_d = '0;
                        flag_d  = 1'b1;
                    end else begin
                        count_d = sum_ext[WIDTH-1:0];
                    end
                end else begin
                    if (c_ext < s_ext) begin
                        count_d = r_ext[WIDTH-1:0];
                        flag_d  = 1'b1;
                    end else begin
                        count_d = diff_ext[WIDTH-1:0];
                    end
                end
            end else begin
                if (dir_q) begin
                    if (sum_ext >= r_ext) begin
                        count_d = r_ext[WIDTH-1:0];
                        dir_d   = 1'b0;
                        flag_d  = 1'b1;
                    end else begin
                        count_d = sum_ext[WIDTH-1:0];
                    end
                end else begin
                    if (c_ext <= s_ext) begin
                        count_d = '0;
                        dir_d   = 1'b1;
                        flag_d  = 1'b1;
                    end else begin
                        count_d = diff_ext[WIDTH-1:0];
                    end
                end
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                count_q <= '0;
                dir_q   <= 1'b1;
                flag_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                dir_q   <= dir_d;
                flag_q  <= flag_d;
            end
        end

        assign count[i*WIDTH +: WIDTH] = count_q;
        assign rollover_flag[i]        = flag_q;
        assign dir_out[i]              = mode[i] ? dir_q : dir[i];
    end

endmodule

// File: tb/tb_multi_flex_counter.sv
// Self-checking bench for multi_flex_counter: directed scenarios plus randomized
// stimulus compared against an integer reference model of the counting rules.
module tb_multi_flex_counter;

    localparam int NC = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            CLK;
    logic            nRST;
    logic [NC-1:0]   en, clear, mode, dir;
    logic [NC*SW-1:0] step;
    logic [NC*W-1:0] rollover_val;
    logic [NC*W-1:0] count;
    logic [NC-1:0]   rollover_flag, dir_out;

    int total = 0;
    int bad   = 0;

    int m_cnt  [NC];
    int m_up   [NC];
    int m_flag [NC];

    multi_flex_counter #(.NUM_CH(NC), .WIDTH(W), .STEP_W(SW)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .clear(clear), .mode(mode), .dir(dir),
        .step(step), .rollover_val(rollover_val), .count(count),
        .rollover_flag(rollover_flag), .dir_out(dir_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int ch, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, ch, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0; m_up[i] = 1; m_flag[i] = 0;
        end
    endtask

    // Applies the counting rules to the inputs present just before the edge.
    task automatic model_edge();
        for (int i = 0; i < NC; i++) begin
            int c, s, r;
            c = m_cnt[i];
            s = int'(step[i*SW +: SW]);
            r = int'(rollover_val[i*W +: W]);
            m_flag[i] = 0;
            if (clear[i]) begin
                m_cnt[i] = 0; m_up[i] = 1;
            end else if (!en[i] || s == 0) begin
                m_cnt[i] = c;
            end else if (c > r) begin
                m_cnt[i] = 0; m_up[i] = 1; m_flag[i] = 1;
            end else if (!mode[i]) begin
                if (dir[i]) begin
                    if (c + s > r) begin m_cnt[i] = 0; m_flag[i] = 1; end
                    else m_cnt[i] = c + s;
                end else begin
                    if (c < s) begin m_cnt[i] = r; m_flag[i] = 1; end
                    else m_cnt[i] = c - s;
                end
            end else if (m_up[i] != 0) begin
                if (c + s >= r) begin m_cnt[i] = r; m_up[i] = 0; m_flag[i] = 1; end
                else m_cnt[i] = c + s;
            end else begin
                if (c <= s) begin m_cnt[i] = 0; m_up[i] = 1; m_flag[i] = 1; end
                else m_cnt[i] = c - s;
            end
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < NC; i++) begin
            chk({tag, "_count"}, i, 32'(count[i*W +: W]), 32'(m_cnt[i]));
            chk({tag, "_flag"},  i, 32'(rollover_flag[i]), 32'(m_flag[i]));
            chk({tag, "_dirout"}, i, 32'(dir_out[i]),
                mode[i] ? 32'(m_up[i]) : 32'(dir[i]));
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        check_model(tag);
    endtask

    initial begin
        int exp0 [7] = '{1, 2, 3, 4, 5, 0, 1};
        int exp1 [7] = '{5, 3, 1, 5, 3, 1, 5};
        int exp2 [7] = '{1, 2, 3, 2, 1, 0, 1};
        int dir2 [7] = '{1, 1, 0, 0, 0, 1, 1};
        int fl0  [7] = '{0, 0, 0, 0, 0, 1, 0};
        int fl1  [7] = '{1, 0, 0, 1, 0, 0, 1};
        int fl2  [7] = '{0, 0, 1, 0, 0, 1, 0};

        nRST = 1'b0;
        clear = '0; en = '0; mode = '0; dir = '0; step = '0; rollover_val = '0;
        model_reset();

        // ch0 up-wrap, ch1 down-wrap step 2, ch2 bounce, ch3 idle
        rollover_val[0*W +: W] = 8'd5; step[0*SW +: SW] = 2'd1; dir[0] = 1'b1; en[0] = 1'b1;
        rollover_val[1*W +: W] = 8'd5; step[1*SW +: SW] = 2'd2; dir[1] = 1'b0; en[1] = 1'b1;
        rollover_val[2*W +: W] = 8'd3; step[2*SW +: SW] = 2'd1; mode[2] = 1'b1; en[2] = 1'b1;
        rollover_val[3*W +: W] = 8'd90;

        @(posedge CLK); @(posedge CLK); #1;
        check_model("reset");
        chk("reset_dirout_bounce", 2, 32'(dir_out[2]), 32'd1);
        nRST = 1'b1;

        for (int k = 0; k < 7; k++) begin
            tick("basic");
            chk("upwrap_seq",   0, 32'(count[0*W +: W]), 32'(exp0[k]));
            chk("upwrap_flag",  0, 32'(rollover_flag[0]), 32'(fl0[k]));
            chk("downwrap_seq", 1, 32'(count[1*W +: W]), 32'(exp1[k]));
            chk("downwrap_flag", 1, 32'(rollover_flag[1]), 32'(fl1[k]));
            chk("bounce_seq",   2, 32'(count[2*W +: W]), 32'(exp2[k]));
            chk("bounce_flag",  2, 32'(rollover_flag[2]), 32'(fl2[k]));
            chk("bounce_dir",   2, 32'(dir_out[2]), 32'(dir2[k]));
        end

        // Advance ch0 to 4, then clear wins over enable
        repeat (3) tick("pre_clear");
        chk("pre_clear_val", 0, 32'(count[0*W +: W]), 32'd4);
        clear[0] = 1'b1;
        tick("clear");
        chk("clear_count", 0, 32'(count[0*W +: W]), 32'd0);
        chk("clear_flag",  0, 32'(rollover_flag[0]), 32'd0);
        clear[0] = 1'b0;
        tick("post_clear");
        en[0] = 1'b0;
        repeat (3) begin
            tick("en_low");
            chk("en_low_hold", 0, 32'(count[0*W +: W]), 32'd1);
        end
        en[0] = 1'b1; step[0*SW +: SW] = 2'd0;
        repeat (2) begin
            tick("step0");
            chk("step0_hold", 0, 32'(count[0*W +: W]), 32'd1);
            chk("step0_noflag", 0, 32'(rollover_flag[0]), 32'd0);
        end

        // Runtime rollover change on ch3
        step[3*SW +: SW] = 2'd2; dir[3] = 1'b1; en[3] = 1'b1;
        repeat (40) tick("ch3_run");
        chk("ch3_at80", 3, 32'(count[3*W +: W]), 32'd80);
        rollover_val[3*W +: W] = 8'd30;
        tick("r_lower");
        chk("r_lower_count", 3, 32'(count[3*W +: W]), 32'd0);
        chk("r_lower_flag",  3, 32'(rollover_flag[3]), 32'd1);
        step[3*SW +: SW] = 2'd1;
        repeat (30) tick("ch3_to30");
        chk("ch3_at30", 3, 32'(count[3*W +: W]), 32'd30);
        tick("ch3_wrap");
        chk("ch3_wrap_count", 3, 32'(count[3*W +: W]), 32'd0);
        chk("ch3_wrap_flag",  3, 32'(rollover_flag[3]), 32'd1);
        rollover_val[3*W +: W] = 8'd0;
        rollover_val[2*W +: W] = 8'd0;
        repeat (3) begin
            tick("r_zero");
            chk("r0_count", 3, 32'(count[3*W +: W]), 32'd0);
            chk("r0_flag",  3, 32'(rollover_flag[3]), 32'd1);
        end

        // Randomized concurrent operation
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NC; i++) begin
                clear[i] = ($urandom_range(0, 15) == 0);
                en[i]    = ($urandom_range(0, 3) != 0);
                dir[i]   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 19) == 0) mode[i] = ~mode[i];
                if ($urandom_range(0, 3) == 0) step[i*SW +: SW] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0)
                    rollover_val[i*W +: W] = ($urandom_range(0, 7) == 0) ?
                        8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            end
            tick("rand");
        end

        // Asynchronous reset between edges
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NC; i++) begin
            chk("async_rst_count", i, 32'(count[i*W +: W]), 32'd0);
            chk("async_rst_flag",  i, 32'(rollover_flag[i]), 32'd0);
        end
        #1;
        nRST = 1'b1;
        clear = '0;
        repeat (20) tick("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_flex_counter.md
# multi_flex_counter

Parametrised, multi-channel successor to the single flex counter. Each of NUM_CH independent channels counts by a programmable step toward a per-channel rollover value. Each channel runs in wrap mode (up or down) or bounce mode (ping-pong between 0 and rollover). The block feeds the fan/PWM and timing logic, which need several concurrently programmable rate counters with rollover pulses.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels
- WIDTH, 8, count and rollover width per channel
- STEP_W, 2, width of per-channel step

Ports (channel i occupies bits [i*W +: W] of packed buses):
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, asynchronous, active-low
- en  in  NUM_CH  per-channel count enable
- clear  in  NUM_CH  per-channel synchronous clear
- mode  in  NUM_CH  0 = wrap, 1 = bounce
- dir  in  NUM_CH  wrap-mode direction: 1 = up, 0 = down; ignored in bounce mode
- step  in  NUM_CH*STEP_W  increment per enabled cycle; 0 = hold
- rollover_val  in  NUM_CH*WIDTH  upper bound R of the range [0, R]
- count  out  NUM_CH*WIDTH  registered count value
- rollover_flag  out  NUM_CH  registered one-cycle pulse on wrap or turn-around
- dir_out  out  NUM_CH  effective direction: dir in wrap mode, internal dir_q in bounce mode

## Operation
- Per-channel state: count_q (WIDTH), dir_q (1, bounce direction), flag_q (1).
- All arithmetic is done in WIDTH+1 bits, so count+step never overflows. Step is zero-extended.
- Per-channel priority at each edge: clear > en=0 > out-of-range > mode update.
- clear=1: count_q <= 0, dir_q <= up, flag_q <= 0. This applies regardless of en.
- en=0 or step=0: count_q and dir_q hold, flag_q <= 0.
- Out-of-range (count_q > R, e.g. R lowered at runtime): count_q <= 0, dir_q <= up, flag_q <= 1.
- Wrap, up: if count_q + step > R, count_q <= 0 and flag_q <= 1. Otherwise count_q <= count_q + step.
- Wrap, down: if count_q < step, count_q <= R and flag_q <= 1. Otherwise count_q <= count_q - step.
- Bounce, dir_q=up: if count_q + step >= R, count_q <= R, dir_q <= down, flag_q <= 1. Otherwise add step.
- Bounce, dir_q=down: if count_q <= step, count_q <= 0, dir_q <= up, flag_q <= 1. Otherwise subtract step.
- R = 0 is legal:
  - count stays 0.
  - Wrap mode flags every enabled cycle with nonzero step.
  - Bounce mode flags every enabled cycle and toggles dir_q.
- Mode switch mid-run: count_q and dir_q are kept. The new mode's rule applies from the next enabled edge.
- Channels are fully independent. No shared state.

## Timing
- Reset (nRST low, asynchronous): count = 0, rollover_flag = 0, dir_q = up, so dir_out = 1 in bounce mode.
- Deassertion is synchronised externally; the first update occurs on the first rising edge with nRST high.
- Latency: inputs sampled at edge N are reflected in count/rollover_flag after edge N (one cycle). There is no combinational input-to-output path, except that dir_out in wrap mode equals dir.
- rollover_flag is high for exactly the cycle in which count holds the wrapped or turned value. It is high on consecutive cycles only if every cycle wraps.
- Reset asserted mid-count clears immediately, without waiting for a clock.
- rollover_val, step, mode and dir may change on any cycle. They take effect at the next edge.

## Test plan
- Reset/basic up-wrap, ch0: R=5, step=1, dir=1, en=1 after nRST rises -> count 1,2,3,4,5,0. rollover_flag high only in the cycle count=0. Period 6.
- Step and down-wrap, ch1: R=5, step=2, dir=0 from count 0 -> count 5,3,1,5. Flag with each 5.
- Bounce, ch2: R=3, step=1, mode=1 -> count 1,2,3,2,1,0,1. Flags at 3 and 0. dir_out 1,1,0,0,0,1,1.
- Clear/enable priority: clear=1 with en=1 mid-count at 4 -> count 0, flag 0. Next, en=0 for 3 cycles -> count holds. Step=0 with en=1 -> count holds, no flag.
- Runtime R change: count at 80, R lowered 90->30 -> next count 0 with flag. Then count 1..30 wraps normally. R=0 with step=1 -> count 0, flag every cycle.
- Channel independence and async reset: all 4 channels with different R/step/mode run concurrently and each matches a reference model. Pulse nRST low mid-cycle -> all counts 0 and flags 0 before the next edge.
